// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU: opcodes, controller phases,
// control-strobe bundle and the ALU-opcode decode.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned PHASE_W  = 3;

    localparam logic [OPCODE_W-1:0] OP_HLT = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OPCODE_W-1:0] OP_ADD = 3'd2;
    localparam logic [OPCODE_W-1:0] OP_AND = 3'd3;
    localparam logic [OPCODE_W-1:0] OP_XOR = 3'd4;
    localparam logic [OPCODE_W-1:0] OP_LDA = 3'd5;
    localparam logic [OPCODE_W-1:0] OP_STO = 3'd6;
    localparam logic [OPCODE_W-1:0] OP_JMP = 3'd7;

    typedef enum logic [PHASE_W-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic ld_ac;
        logic wr;
        logic data_e;
        logic halt;
    } strobes_t;

    // Opcodes that read a memory operand into the ALU.
    function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath/memory signal bundle; the controller is the master.
interface cpu_controller_if;
    import cpu_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                resume;

    logic                sel;
    logic                rd;
    logic                ld_ir;
    logic                inc_pc;
    logic                ld_pc;
    logic                ld_ac;
    logic                wr;
    logic                data_e;
    logic                halt;
    logic                halted;
    logic [PHASE_W-1:0]  phase;

    modport master (
        input  opcode, zero, mem_ready, resume,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, halted, phase
    );

    modport slave (
        output opcode, zero, mem_ready, resume,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, halted, phase
    );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// Pure combinational decode of (phase, opcode, zero, halted) into control strobes.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  phase_e              phase,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                halted,
    output strobes_t            strobes
);

    logic aluop;
    logic is_skz;
    logic is_sto;
    logic is_jmp;

    assign aluop  = is_aluop(opcode);
    assign is_skz = (opcode == OP_SKZ);
    assign is_sto = (opcode == OP_STO);
    assign is_jmp = (opcode == OP_JMP);

    // While halted every strobe stays low, including the PC address select.
    always_comb begin
        strobes = '0;
        if (!halted) begin
            case (phase)
                PH_INST_ADDR: begin
                    strobes.sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    strobes.sel = 1'b1;
                    strobes.rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    strobes.sel   = 1'b1;
                    strobes.rd    = 1'b1;
                    strobes.ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    strobes.inc_pc = 1'b1;
                    strobes.halt   = (opcode == OP_HLT);
                end
                PH_OP_FETCH: begin
                    strobes.rd = aluop;
                end
                PH_ALU_OP: begin
                    strobes.rd     = aluop;
                    strobes.inc_pc = is_skz & zero;
                    strobes.ld_pc  = is_jmp;
                    strobes.data_e = is_sto;
                end
                PH_STORE: begin
                    strobes.rd     = aluop;
                    strobes.ld_ac  = aluop;
                    strobes.ld_pc  = is_jmp;
                    strobes.wr     = is_sto;
                    strobes.data_e = is_sto;
                end
                default: begin
                    strobes = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: 8-phase machine cycle with memory-ready stalls and a
// HALT state entered on HLT and left by a resume pulse.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    cpu_controller_if.master  bus
);

    phase_e   phase_q;
    phase_e   phase_d;
    logic     halted_q;
    logic     halted_d;
    logic     aluop;
    strobes_t strobes;

    assign aluop = is_aluop(bus.opcode);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Phase stays at OP_ADDR while halted; resuming continues at OP_FETCH.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (halted_q) begin
            if (bus.resume) begin
                halted_d = 1'b0;
                phase_d  = PH_OP_FETCH;
            end
        end else begin
            case (phase_q)
                PH_INST_FETCH: begin
                    if (bus.mem_ready) phase_d = PH_INST_LOAD;
                end
                PH_OP_ADDR: begin
                    if (bus.opcode == OP_HLT) halted_d = 1'b1;
                    else                      phase_d  = PH_OP_FETCH;
                end
                PH_OP_FETCH: begin
                    if (!aluop || bus.mem_ready) phase_d = PH_ALU_OP;
                end
                default: begin
                    phase_d = phase_e'(PHASE_W'(phase_q + PHASE_W'(1)));
                end
            endcase
        end
    end

    cpu_ctrl_decode u_decode (
        .phase   (phase_q),
        .opcode  (bus.opcode),
        .zero    (bus.zero),
        .halted  (halted_q),
        .strobes (strobes)
    );

    assign bus.sel    = strobes.sel;
    assign bus.rd     = strobes.rd;
    assign bus.ld_ir  = strobes.ld_ir;
    assign bus.inc_pc = strobes.inc_pc;
    assign bus.ld_pc  = strobes.ld_pc;
    assign bus.ld_ac  = strobes.ld_ac;
    assign bus.wr     = strobes.wr;
    assign bus.data_e = strobes.data_e;
    assign bus.halt   = strobes.halt;
    assign bus.halted = halted_q;
    assign bus.phase  = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: fixed vector table, hand sequences
// for halt/stall/reset corners, and randomized instructions against a model.
module tb_cpu_controller;

    localparam logic [2:0] T_HLT = 3'd0, T_SKZ = 3'd1, T_ADD = 3'd2, T_AND = 3'd3;
    localparam logic [2:0] T_XOR = 3'd4, T_LDA = 3'd5, T_STO = 3'd6, T_JMP = 3'd7;

    // Strobe vector bit order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
    typedef struct {
        logic [2:0] op;
        logic       z;
        logic [2:0] ph;
        logic [8:0] st;
    } vec_t;

    typedef struct {
        logic [2:0] op;
        logic       z;
        logic       mr;
        logic       rs;
        logic [2:0] ph;
        logic       hd;
        logic [8:0] st;
    } cyc_t;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];

    cpu_controller_if bus();

    cpu_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [8:0] obs();
        return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                bus.ld_ac, bus.wr, bus.data_e, bus.halt};
    endfunction

    // Expected strobes for a running (not halted) controller, straight from the phase table.
    function automatic logic [8:0] model(input int p, input logic [2:0] op, input logic z);
        logic alu, s, r, li, ip, lp, la, w, de, h;
        alu = (op == T_ADD) || (op == T_AND) || (op == T_XOR) || (op == T_LDA);
        {s, r, li, ip, lp, la, w, de, h} = 9'b0;
        case (p)
            0: s = 1'b1;
            1: begin s = 1'b1; r = 1'b1; end
            2, 3: begin s = 1'b1; r = 1'b1; li = 1'b1; end
            4: begin ip = 1'b1; h = (op == T_HLT); end
            5: r = alu;
            6: begin r = alu; ip = (op == T_SKZ) && z; lp = (op == T_JMP); de = (op == T_STO); end
            default: begin
                r = alu; la = alu; lp = (op == T_JMP); w = (op == T_STO); de = (op == T_STO);
            end
        endcase
        return {s, r, li, ip, lp, la, w, de, h};
    endfunction

    function automatic cyc_t mk(input logic [2:0] op, input logic z, input logic mr,
                                input logic rs, input logic [2:0] ph, input logic hd,
                                input logic [8:0] st);
        cyc_t c;
        c.op = op; c.z = z; c.mr = mr; c.rs = rs; c.ph = ph; c.hd = hd; c.st = st;
        return c;
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Entered at posedge+1; leaves at the next posedge+1.
    task automatic do_cycle(input cyc_t c, input string tag);
        bus.opcode    = c.op;
        bus.zero      = c.z;
        bus.mem_ready = c.mr;
        bus.resume    = c.rs;
        #1;
        check({tag, " phase"},   9'(bus.phase),  9'(c.ph));
        check({tag, " halted"},  9'(bus.halted), 9'(c.hd));
        check({tag, " strobes"}, obs(),          c.st);
        @(posedge clock);
        #1;
    endtask

    // Expands one instruction into its expected cycle-by-cycle trace, then plays it.
    task automatic run_instr(input logic [2:0] op, input logic z, input int s_if,
                             input int s_of, input int n_halt, input string tag);
        cyc_t q[$];
        logic alu;
        alu = (op == T_ADD) || (op == T_AND) || (op == T_XOR) || (op == T_LDA);
        for (int p = 0; p < 8; p++) begin
            logic gate;
            gate = (p == 1) || (p == 5 && alu);
            if (p == 1) repeat (s_if) q.push_back(mk(op, z, 1'b0, 1'($urandom), 3'(p), 1'b0, model(p, op, z)));
            if (p == 5 && alu) repeat (s_of) q.push_back(mk(op, z, 1'b0, 1'($urandom), 3'(p), 1'b0, model(p, op, z)));
            q.push_back(mk(op, z, gate ? 1'b1 : 1'($urandom), 1'($urandom), 3'(p), 1'b0, model(p, op, z)));
            if (p == 4 && op == T_HLT)
                for (int k = 0; k < n_halt; k++)
                    q.push_back(mk(op, z, 1'($urandom), (k == n_halt - 1), 3'd4, 1'b1, 9'b0));
        end
        foreach (q[i]) do_cycle(q[i], $sformatf("%s cyc%0d", tag, i));
    endtask

    task automatic add_row(input logic [2:0] op, input logic z, input logic [2:0] ph, input logic [8:0] st);
        vec_t v;
        v.op = op; v.z = z; v.ph = ph; v.st = st;
        tbl.push_back(v);
    endtask

    initial begin
        // Consecutive nominal cycles of ADD, SKZ(zero=1), SKZ(zero=0), JMP, STO.
        add_row(T_ADD, 0, 0, 9'b100000000); add_row(T_ADD, 0, 1, 9'b110000000);
        add_row(T_ADD, 0, 2, 9'b111000000); add_row(T_ADD, 0, 3, 9'b111000000);
        add_row(T_ADD, 0, 4, 9'b000100000); add_row(T_ADD, 0, 5, 9'b010000000);
        add_row(T_ADD, 0, 6, 9'b010000000); add_row(T_ADD, 0, 7, 9'b010001000);
        add_row(T_SKZ, 1, 0, 9'b100000000); add_row(T_SKZ, 1, 1, 9'b110000000);
        add_row(T_SKZ, 1, 2, 9'b111000000); add_row(T_SKZ, 1, 3, 9'b111000000);
        add_row(T_SKZ, 1, 4, 9'b000100000); add_row(T_SKZ, 1, 5, 9'b000000000);
        add_row(T_SKZ, 1, 6, 9'b000100000); add_row(T_SKZ, 1, 7, 9'b000000000);
        add_row(T_SKZ, 0, 0, 9'b100000000); add_row(T_SKZ, 0, 1, 9'b110000000);
        add_row(T_SKZ, 0, 2, 9'b111000000); add_row(T_SKZ, 0, 3, 9'b111000000);
        add_row(T_SKZ, 0, 4, 9'b000100000); add_row(T_SKZ, 0, 5, 9'b000000000);
        add_row(T_SKZ, 0, 6, 9'b000000000); add_row(T_SKZ, 0, 7, 9'b000000000);
        add_row(T_JMP, 0, 0, 9'b100000000); add_row(T_JMP, 0, 1, 9'b110000000);
        add_row(T_JMP, 0, 2, 9'b111000000); add_row(T_JMP, 0, 3, 9'b111000000);
        add_row(T_JMP, 0, 4, 9'b000100000); add_row(T_JMP, 0, 5, 9'b000000000);
        add_row(T_JMP, 0, 6, 9'b000010000); add_row(T_JMP, 0, 7, 9'b000010000);
        add_row(T_STO, 0, 0, 9'b100000000); add_row(T_STO, 0, 1, 9'b110000000);
        add_row(T_STO, 0, 2, 9'b111000000); add_row(T_STO, 0, 3, 9'b111000000);
        add_row(T_STO, 0, 4, 9'b000100000); add_row(T_STO, 0, 5, 9'b000000000);
        add_row(T_STO, 0, 6, 9'b000000010); add_row(T_STO, 0, 7, 9'b000000110);

        reset         = 1'b1;
        bus.opcode    = T_ADD;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        bus.resume    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset phase",   9'(bus.phase),  9'd0);
        check("reset halted",  9'(bus.halted), 9'd0);
        check("reset strobes", obs(),          9'b100000000);
        reset = 1'b0;

        foreach (tbl[i])
            do_cycle(mk(tbl[i].op, tbl[i].z, 1'b1, 1'b0, tbl[i].ph, 1'b0, tbl[i].st),
                     $sformatf("table row%0d", i));

        run_instr(T_HLT, 1'b0, 0, 0, 3, "hlt resume3");
        run_instr(T_LDA, 1'b1, 2, 1, 0, "lda stall");
        run_instr(T_SKZ, 1'b1, 0, 3, 0, "skz ignores ready");

        // Async reset during ALU_OP of STO aborts the store at once.
        for (int p = 0; p < 6; p++)
            do_cycle(mk(T_STO, 1'b0, 1'b1, 1'b0, 3'(p), 1'b0, model(p, T_STO, 1'b0)), "sto pre-reset");
        #1;
        check("sto phase6",  9'(bus.phase), 9'd6);
        check("sto data_e6", obs(),         9'b000000010);
        reset = 1'b1;
        #1;
        check("async reset phase",   9'(bus.phase), 9'd0);
        check("async reset strobes", obs(),         9'b100000000);
        @(posedge clock);
        #1;
        check("reset next phase",   9'(bus.phase), 9'd0);
        check("reset next strobes", obs(),         9'b100000000);
        reset = 1'b0;

        // Reset and resume together while halted: reset wins.
        for (int p = 0; p < 5; p++)
            do_cycle(mk(T_HLT, 1'b0, 1'b1, 1'b0, 3'(p), 1'b0, model(p, T_HLT, 1'b0)), "hlt pre-reset");
        do_cycle(mk(T_HLT, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 9'b0), "halted wait");
        bus.resume = 1'b1;
        reset      = 1'b1;
        @(posedge clock);
        #1;
        check("reset+resume phase",   9'(bus.phase),  9'd0);
        check("reset+resume halted",  9'(bus.halted), 9'd0);
        check("reset+resume strobes", obs(),          9'b100000000);
        reset      = 1'b0;
        bus.resume = 1'b0;

        for (int n = 0; n < 80; n++)
            run_instr(3'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(1, 4), $sformatf("rand%0d", n));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
